// File: rtl/pwm_capture_if.sv
// Bundle of the measured PWM input and the published measurement results.
interface pwm_capture_if #(
    parameter int unsigned CNT_W = 24
);
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] low_time;
    logic [6:0]       duty_pct;
    logic             valid;
    logic             no_signal;
    logic             overrun;

    // Drives the PWM pin and observes the results.
    modport master (
        output pwm_in,
        input  period, low_time, duty_pct, valid, no_signal, overrun
    );

    // The capture block itself.
    modport slave (
        input  pwm_in,
        output period, low_time, duty_pct, valid, no_signal, overrun
    );
endinterface

// File: rtl/pwm_capture.sv
// Period / low-time / duty measurement of an active-low PWM input, with timeout.
module pwm_capture #(
    parameter int unsigned      CNT_W   = 24,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(2_700_000)
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_capture_if.slave   bus
);

    localparam int unsigned      NUM_W   = CNT_W + 7;
    localparam int unsigned      BIT_W   = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        ST_IDLE,
        ST_MEAS
    } meas_state_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    meas_state_t      meas_state;
    div_state_t       div_state;

    logic             sync1;
    logic             pwm_s;
    logic             pwm_d;
    logic             fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] low_acc;
    logic [CNT_W-1:0] period_c;
    logic [CNT_W-1:0] low_c;

    logic [NUM_W-1:0] num;
    logic [CNT_W-1:0] rem;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W:0]   rem_sh;
    logic [CNT_W:0]   rem_sub;
    logic             rem_ge;

    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] low_q;
    logic [6:0]       duty_q;
    logic             valid_q;
    logic             no_sig_q;
    logic             overrun_q;

    // Resync the asynchronous pin; flops reset high (idle level) so reset alone never fakes a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            pwm_s <= 1'b1;
            pwm_d <= 1'b1;
        end else begin
            sync1 <= bus.pwm_in;
            pwm_s <= sync1;
            pwm_d <= pwm_s;
        end
    end

    assign fall = pwm_d & ~pwm_s;

    // One restoring-division step: remainder shifted with the next numerator bit, trial subtract.
    assign rem_sh  = {rem, num[NUM_W-1]};
    assign rem_ge  = (rem_sh >= {1'b0, period_c});
    assign rem_sub = rem_sh - {1'b0, period_c};

    // Measurement FSM, divider FSM and the published result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_state <= ST_IDLE;
            div_state  <= DIV_IDLE;
            cnt        <= '0;
            low_acc    <= '0;
            period_c   <= '0;
            low_c      <= '0;
            num        <= '0;
            rem        <= '0;
            bit_cnt    <= '0;
            period_q   <= '0;
            low_q      <= '0;
            duty_q     <= '0;
            valid_q    <= 1'b0;
            no_sig_q   <= 1'b1;
            overrun_q  <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;

            // Divider: one quotient bit per cycle, quotient accumulates in num's low bits.
            case (div_state)
                DIV_RUN: begin
                    rem     <= rem_ge ? rem_sub[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                    num     <= {num[NUM_W-2:0], rem_ge};
                    bit_cnt <= bit_cnt - BIT_W'(1);
                    if (bit_cnt == BIT_W'(1)) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    period_q  <= period_c;
                    low_q     <= low_c;
                    duty_q    <= num[6:0];
                    valid_q   <= 1'b1;
                    no_sig_q  <= 1'b0;
                    div_state <= DIV_IDLE;
                end
                default: begin
                    div_state <= DIV_IDLE;
                end
            endcase

            // Measurement: a fall closes one period and opens the next; a fall always beats timeout.
            case (meas_state)
                ST_IDLE: begin
                    if (fall) begin
                        cnt        <= CNT_ONE;
                        low_acc    <= CNT_ONE;
                        meas_state <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (fall) begin
                        cnt     <= CNT_ONE;
                        low_acc <= CNT_ONE;
                        if (div_state == DIV_IDLE) begin
                            period_c  <= cnt;
                            low_c     <= low_acc;
                            num       <= NUM_W'(low_acc) * NUM_W'(100);
                            rem       <= '0;
                            bit_cnt   <= BIT_W'(NUM_W);
                            div_state <= DIV_RUN;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (cnt == TIMEOUT) begin
                        meas_state <= ST_IDLE;
                        cnt        <= '0;
                        low_acc    <= '0;
                        no_sig_q   <= 1'b1;
                        period_q   <= '0;
                        low_q      <= '0;
                        duty_q     <= pwm_s ? 7'd0 : 7'd100;
                        valid_q    <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (!pwm_s && (low_acc != TIMEOUT)) begin
                            low_acc <= low_acc + CNT_ONE;
                        end
                    end
                end
                default: begin
                    meas_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.period    = period_q;
    assign bus.low_time  = low_q;
    assign bus.duty_pct  = duty_q;
    assign bus.valid     = valid_q;
    assign bus.no_signal = no_sig_q;
    assign bus.overrun   = overrun_q;

endmodule
